data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// - Parametrised data memory for the RISC-V load/store stage; successor to the flat word memory.
// - Byte-addressed request/response interface with byte/half/word stores (lane masking),
//   sign/zero-extended loads, misalignment detection and a registered 1-cycle response.
// - Sits between the MEM stage and on-chip RAM; one request accepted per cycle.
// PARAMETERS
// - DATA_W   32   word width in bits; must be 32 (byte lanes = DATA_W/8 = 4)
// - DEPTH    1024 number of words; power of two
// - ADDR_W   $clog2(DEPTH)+2  byte-address width (derived, do not override)
// PORTS
// - CLK          in   1       clock, all state on rising edge
// - RST          in   1       asynchronous reset, active-high
// - req_valid    in   1       request present
// - req_ready    out  1       block can accept a request this cycle
// - req_we       in   1       1 = store, 0 = load
// - req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
// - req_unsigned in   1       load zero-extends when 1 (LBU/LHU); ignored for word/stores
// - req_addr     in   ADDR_W  byte address
// - req_wdata    in   DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
// - rsp_valid    out  1       response pulse, one per accepted request
// - rsp_rdata    out  DATA_W  extended load data; 0 for stores and errors
// - rsp_err      out  1       misaligned or illegal-size request
// BEHAVIOUR
// - Reset: req_ready=0 while RST high, rsp_valid=0, rsp_rdata=0, rsp_err=0; pending response dropped.
// - FSM: INIT -> IDLE. Without macro INIT lasts exactly one cycle after RST falls; req_ready=1 in IDLE only.
// - Accept = req_valid & req_ready. Response registered: rsp_* valid exactly 1 cycle after accept,
//   rsp_valid high for one cycle; no response-side backpressure. Back-to-back accepts -> back-to-back responses.
// - Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
// - Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always errors.
//   Error -> rsp_err=1, rsp_rdata=0, memory unchanged.
// - Store: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0}+1:{addr[1],0}
//   with wdata[15:0]; word writes all lanes. Unselected lanes keep old contents. rsp_rdata=0.
// - Load: select byte/half at lane, sign-extend from bit 7/15 unless req_unsigned; word passes through.
// - Ordering: load accepted the cycle after a store to the same word returns the stored data.
// - Array contents are not cleared by RST (without macro); reads of never-written words are undefined.
// - RST asserted mid-request: in-flight store committed only if its accepting edge preceded RST; no rsp after RST.
// CONFIGURATION
// - DMEM_CLEAR_EN defined: after RST falls, FSM stays in INIT for DEPTH cycles, a word counter
//   writes 0 to every word (index 0..DEPTH-1, one per cycle), req_ready=0 throughout, then IDLE.
//   RST during INIT restarts the sweep from index 0.
// - DMEM_CLEAR_EN undefined: no sweep logic, INIT is a single cycle, contents power-up undefined.
// TESTING
// - Word store 0xDEADBEEF @0x10, load word @0x10 next cycle -> rsp_valid 1 cycle later, rdata 0xDEADBEEF, err 0.
// - Then byte store 0x7F @0x11; LB @0x11 -> 0x0000007F; word @0x10 -> 0xDEAD7FEF; LB @0x13 -> 0xFFFFFFDE, LBU -> 0x000000DE.
// - Half store 0x8001 @0x12; LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001; word @0x10 -> 0x80017FEF.
// - Misaligned: LH @0x13, SW @0x12, size 11 @0x10 -> each rsp_err=1, rdata 0; word @0x10 still 0x80017FEF.
// - Back-to-back: 8 consecutive accepts -> 8 consecutive rsp_valid pulses, 1-cycle latency, none lost;
//   RST raised with one request in flight -> rsp_valid 0 next cycle, req_ready 0 while RST high.
// - DMEM_CLEAR_EN, DEPTH=16: req_ready low 16 cycles after RST falls, then any word load returns 0;
//   RST pulse at sweep cycle 5 -> sweep restarts, ready rises 16 cycles after second RST release.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with lane-masked stores, extended loads and a 1-cycle response.
// Optional DMEM_CLEAR_EN: zero every word in a DEPTH-cycle sweep after reset.
module data_mem_ctrl #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
    input logic             CLK,
    input logic             RST,
    data_mem_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic {StInit, StIdle} state_e;

    state_e state_q, state_d;
    logic   ready;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  widx;
    logic [1:0]        lane;
    logic              accept;
    logic              err;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wr_word;
    logic              store_en;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] load_data;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef DMEM_CLEAR_EN
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0] clr_idx_q;
    logic             clr_we;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_idx_q <= '0;
        end else if (clr_we) begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
`ifdef DMEM_CLEAR_EN
        clr_we  = 1'b0;
`endif
        unique case (state_q)
            StInit: begin
`ifdef DMEM_CLEAR_EN
                clr_we = 1'b1;
                if (clr_idx_q == LastIdx) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            StIdle: begin
                ready = 1'b1;
            end
            default: state_d = StInit;
        endcase
    end

    assign bus.req_ready = ready;

    // Request decode: alignment, byte enables and lane-replicated store data.
    always_comb begin
        widx    = bus.req_addr[ADDR_W-1:2];
        lane    = bus.req_addr[1:0];
        accept  = bus.req_valid & ready;
        err     = 1'b1;
        be      = '0;
        wr_word = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                err     = 1'b0;
                be      = LANES'(1) << lane;
                wr_word = {LANES{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                err     = lane[0];
                be      = LANES'(3) << {lane[1], 1'b0};
                wr_word = {(LANES / 2){bus.req_wdata[15:0]}};
            end
            2'b10: begin
                err = |lane;
                be  = '1;
            end
            default: err = 1'b1;
        endcase
        store_en = accept & bus.req_we & ~err;
    end

    always_ff @(posedge CLK) begin
`ifdef DMEM_CLEAR_EN
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else
`endif
        if (store_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Half loads are aligned, so shifting by lane*8 lands them at bit 0 as well.
    always_comb begin
        rd_word   = mem[widx];
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = rd_word;
        case (bus.req_size)
            2'b00: load_data = {{(DATA_W - 8){rd_shift[7] & ~bus.req_unsigned}}, rd_shift[7:0]};
            2'b01: load_data = {{(DATA_W - 16){rd_shift[15] & ~bus.req_unsigned}},
                                rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept & err;
        rsp_rdata_d = '0;
        if (accept && !err && !bus.req_we) begin
            rsp_rdata_d = load_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses queued at drive time, checked on response.
module tb_data_mem_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH) + 2;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic due;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    data_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // A response is due exactly one cycle after an accepting edge; reset drops it.
    always @(posedge CLK or posedge RST) begin
        if (RST) due <= 1'b0;
        else     due <= bus.req_valid && bus.req_ready;
    end

    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end else if (due) begin
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rsp_has_exp", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rd);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end else begin
            check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        end
    end

    // Drive one request for one cycle; leaves it asserted so calls chain back-to-back.
    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        check("req_ready", 32'(bus.req_ready), 32'd1);
        e.rd  = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ready_latency(input int exp_cycles);
        int n;
        n = 0;
        while (!bus.req_ready && n < int'(DEPTH) + 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'(exp_cycles));
    endtask

    localparam int InitCycles =
`ifdef DMEM_CLEAR_EN
        DEPTH;
`else
        1;
`endif

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
`ifdef DMEM_CLEAR_EN
        repeat (5) @(posedge CLK);
        #1;
        check("ready_mid_sweep", 32'(bus.req_ready), 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
`endif
        ready_latency(InitCycles);
`ifdef DMEM_CLEAR_EN
        req(1'b0, 2'b10, 1'b0, 6'h2C, 32'h0, 32'h0, 1'b0);
`endif

        // Word, byte and half stores with sign/zero-extended loads.
        req(1'b1, 2'b10, 1'b0, 6'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        req(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        req(1'b1, 2'b00, 1'b0, 6'h11, 32'hFFFFFF7F, 32'h0, 1'b0);
        req(1'b0, 2'b00, 1'b0, 6'h11, 32'h0, 32'h0000007F, 1'b0);
        req(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
        req(1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        req(1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 32'h000000DE, 1'b0);
        req(1'b0, 2'b00, 1'b0, 6'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        req(1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 32'h00007FEF, 1'b0);
        idle(1);
        req(1'b1, 2'b01, 1'b0, 6'h12, 32'h12348001, 32'h0, 1'b0);
        req(1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 32'hFFFF8001, 1'b0);
        req(1'b0, 2'b01, 1'b1, 6'h12, 32'h0, 32'h00008001, 1'b0);
        req(1'b0, 2'b10, 1'b1, 6'h10, 32'h0, 32'h80017FEF, 1'b0);

        // Misaligned and illegal-size requests must not touch memory.
        req(1'b0, 2'b01, 1'b0, 6'h13, 32'h0, 32'h0, 1'b1);
        req(1'b1, 2'b10, 1'b0, 6'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        req(1'b0, 2'b11, 1'b0, 6'h10, 32'h0, 32'h0, 1'b1);
        req(1'b1, 2'b11, 1'b0, 6'h10, 32'h0, 32'h0, 1'b1);
        req(1'b1, 2'b01, 1'b0, 6'h11, 32'h0000FFFF, 32'h0, 1'b1);
        req(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 32'h80017FEF, 1'b0);
        idle(2);

        // Sixteen consecutive accepts: eight word stores then eight loads.
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 2'b10, 1'b0, ADDR_W'(32 + 4 * i), 32'hA5000000 | (32'h111 * i),
                32'h0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 2'b10, 1'b0, ADDR_W'(32 + 4 * i), 32'h0, 32'hA5000000 | (32'h111 * i),
                1'b0);
        end
        idle(2);

        // Reset raised with a store in flight: no response, but the store is committed.
        req(1'b1, 2'b10, 1'b0, 6'h04, 32'h12345678, 32'h0, 1'b0);
        bus.req_valid = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        ready_latency(InitCycles);
`ifdef DMEM_CLEAR_EN
        req(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'h0, 1'b0);
`else
        req(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'h12345678, 1'b0);
`endif
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
